cpu_run_ctrl: RTL

Run/step/breakpoint controller for the 5-stage MIPS pipeline, driven by the display clock domain's debounced buttons and SW[0].
- Produces the pipeline-wide advance enable (cpu_en) that freezes or releases every pipeline register.
- Implements free run, single/multi-cycle step, and one PC breakpoint.
- Converts the interrupt button into a held request/acknowledge handshake toward the CP0 logic.

---
 rtl/cpu_run_ctrl_if.sv | 29 ++
 rtl/cpu_run_ctrl.sv | 104 ++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl_if.sv
// Signal bundle between the debug front panel / pipeline and the run controller.
// CNT_W must match the controller's CNT_W so adv_count widths line up.
interface cpu_run_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             debug_en;
  logic             step_btn;
  logic             irq_btn;
  logic             brk_en;
  logic [31:0]      brk_addr;
  logic [31:0]      if_pc;
  logic             if_valid;
  logic             irq_ack;
  logic             cpu_en;
  logic             halted;
  logic             brk_hit;
  logic             irq_req;
  logic [CNT_W-1:0] adv_count;

  modport master (
    output debug_en, step_btn, irq_btn, brk_en, brk_addr, if_pc, if_valid, irq_ack,
    input  cpu_en, halted, brk_hit, irq_req, adv_count
  );

  modport slave (
    input  debug_en, step_btn, irq_btn, brk_en, brk_addr, if_pc, if_valid, irq_ack,
    output cpu_en, halted, brk_hit, irq_req, adv_count
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint controller: generates the pipeline-wide advance enable
// and turns the interrupt button into a held request toward CP0.
module cpu_run_ctrl #(
  parameter int STEP_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic clk,
  input  logic rst,
  cpu_run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_RUN, S_HALT, S_STEP, S_BRK} state_t;

  localparam logic [7:0] STEP_LOAD = 8'(STEP_CYCLES - 1);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             skip_q, skip_d;
  logic             step_q, irq_q;
  logic             halted_q, brk_hit_q, irq_req_q;
  logic [CNT_W-1:0] adv_q;

  logic step_rise, irq_rise, match, cpu_en;

  assign step_rise = bus.step_btn & ~step_q;
  assign irq_rise  = bus.irq_btn & ~irq_q;

  // Byte offset bits of the PCs take no part in the compare.
  assign match = bus.brk_en & bus.debug_en & bus.if_valid & ~skip_q &
                 (bus.if_pc[31:2] == bus.brk_addr[31:2]);

  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{bus.if_pc[1:0], bus.brk_addr[1:0]};

  assign cpu_en = ((state_q == S_RUN) & ~match) | (state_q == S_STEP);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    // skip survives until the breakpointed instruction has advanced once
    skip_d  = skip_q & ~cpu_en;
    case (state_q)
      S_RUN: begin
        if (match)             state_d = S_BRK;
        else if (bus.debug_en) state_d = S_HALT;
      end
      S_HALT: begin
        if (!bus.debug_en) state_d = S_RUN;
        else if (step_rise) begin
          state_d = S_STEP;
          cnt_d   = STEP_LOAD;
        end
      end
      S_STEP: begin
        if (cnt_q == 8'd0) state_d = bus.debug_en ? S_HALT : S_RUN;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_BRK: begin
        if (!bus.debug_en) begin
          state_d = S_RUN;
          skip_d  = 1'b1;
        end else if (step_rise) begin
          state_d = S_STEP;
          skip_d  = 1'b1;
          cnt_d   = STEP_LOAD;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RUN;
      cnt_q     <= 8'd0;
      skip_q    <= 1'b0;
      step_q    <= 1'b1;
      irq_q     <= 1'b1;
      halted_q  <= 1'b0;
      brk_hit_q <= 1'b0;
      irq_req_q <= 1'b0;
      adv_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      skip_q    <= skip_d;
      step_q    <= bus.step_btn;
      irq_q     <= bus.irq_btn;
      halted_q  <= (state_q == S_HALT) | (state_q == S_BRK);
      brk_hit_q <= (state_q == S_BRK);
      // a fresh request outranks a coincident acknowledge
      if (irq_rise)         irq_req_q <= 1'b1;
      else if (bus.irq_ack) irq_req_q <= 1'b0;
      if (cpu_en) adv_q <= adv_q + CNT_W'(1);
    end
  end

  assign bus.cpu_en    = cpu_en;
  assign bus.halted    = halted_q;
  assign bus.brk_hit   = brk_hit_q;
  assign bus.irq_req   = irq_req_q;
  assign bus.adv_count = adv_q;

endmodule
